csr_trap_regs: RTL

- Machine-mode trap CSR file that consumes the trap-commit interface: cause, badaddr, epc and status update strobes.
- Also serves software CSR read/write (CSRRW/CSRRS/CSRRC already resolved to a write value by the EXU), and restores status on MRET.
- Holds mstatus, mie, mtvec, mscratch, mepc, mcause, mtval and a 64-bit mcycle counter.
- Exports mepc, mtvec and the interrupt-enable state to the PC/redirect and IRQ logic.

---
 rtl/csr_trap_regs_pkg.sv | 59 +++++
 rtl/csr_cycle_cnt.sv | 36 +++
 rtl/csr_trap_regs.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/csr_trap_regs_pkg.sv
// Shared constants for the machine-mode trap CSR file: CSR addresses,
// mstatus/mie field positions, default widths and reset values.
package csr_trap_regs_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int PC_SIZE_DEF   = 32;
  localparam int ADDR_SIZE_DEF = 32;

  localparam logic [31:0] MTVEC_RESET_DEF = 32'h0000_0000;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  localparam int MIE_MSIE_BIT = 3;
  localparam int MIE_MTIE_BIT = 7;
  localparam int MIE_MEIE_BIT = 11;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  // Field order matches the exported mie_r bus {MEIE, MTIE, MSIE}.
  typedef struct packed {
    logic meie;
    logic mtie;
    logic msie;
  } mie_t;

  function automatic logic [31:0] mstatus_pack(input mstatus_t s);
    logic [31:0] v;
    v = '0;
    v[MSTATUS_MIE_BIT]                      = s.mie;
    v[MSTATUS_MPIE_BIT]                     = s.mpie;
    v[MSTATUS_MPP_LSB+1:MSTATUS_MPP_LSB]    = 2'b11;
    return v;
  endfunction

  function automatic logic [31:0] mie_pack(input mie_t s);
    logic [31:0] v;
    v = '0;
    v[MIE_MSIE_BIT] = s.msie;
    v[MIE_MTIE_BIT] = s.mtie;
    v[MIE_MEIE_BIT] = s.meie;
    return v;
  endfunction

endpackage

// File: rtl/csr_cycle_cnt.sv
// Free-running 2*W-bit cycle counter with independent half writes and a
// stop input; a write in a cycle replaces the increment for that cycle.
module csr_cycle_cnt #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stop_i,
  input  logic           wr_lo_i,
  input  logic           wr_hi_i,
  input  logic [W-1:0]   wdata_i,
  output logic [2*W-1:0] cnt_o
);

  logic [2*W-1:0] cnt_q;
  logic [2*W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[W-1:0]   = wdata_i;
      if (wr_hi_i) cnt_d[2*W-1:W] = wdata_i;
    end else if (!stop_i) begin
      // Full-width add carries low into high within the same cycle.
      cnt_d = cnt_q + {{(2*W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_trap_regs.sv
// Machine-mode trap CSR file: trap-commit and MRET updates, software CSR
// access with a combinational read mux, and the mcycle counter.
module csr_trap_regs
  import csr_trap_regs_pkg::*;
#(
  parameter int                 XLEN        = XLEN_DEF,
  parameter int                 PC_SIZE     = PC_SIZE_DEF,
  parameter int                 ADDR_SIZE   = ADDR_SIZE_DEF,
  parameter logic [PC_SIZE-1:0] MTVEC_RESET = PC_SIZE'(MTVEC_RESET_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmt_cause_ena,
  input  logic [XLEN-1:0]      cmt_cause,
  input  logic                 cmt_badaddr_ena,
  input  logic [ADDR_SIZE-1:0] cmt_badaddr,
  input  logic                 cmt_epc_ena,
  input  logic [PC_SIZE-1:0]   cmt_epc,
  input  logic                 cmt_status_ena,
  input  logic                 cmt_mret_ena,
  input  logic                 cycle_stop,
  input  logic [11:0]          csr_idx,
  input  logic                 csr_rd_en,
  input  logic                 csr_wr_en,
  input  logic [XLEN-1:0]      csr_wdata,
  output logic [XLEN-1:0]      csr_rdata,
  output logic                 csr_access_ilgl,
  output logic [PC_SIZE-1:0]   csr_mepc_r,
  output logic [PC_SIZE-1:0]   csr_mtvec_r,
  output logic                 status_mie_r,
  output logic [2:0]           mie_r
);

  localparam logic [PC_SIZE-1:0] EPC_MASK  = ~PC_SIZE'(1);
  localparam logic [PC_SIZE-1:0] TVEC_MASK = ~PC_SIZE'(3);

  mstatus_t             mstatus_q, mstatus_d;
  mie_t                 mie_q, mie_d;
  logic [PC_SIZE-1:0]   mtvec_q, mtvec_d;
  logic [XLEN-1:0]      mscratch_q, mscratch_d;
  logic [PC_SIZE-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]      mcause_q, mcause_d;
  logic [ADDR_SIZE-1:0] mtval_q, mtval_d;
  logic [2*XLEN-1:0]    mcycle;

  logic [XLEN-1:0] rdata;
  logic            hit;
  logic            sw_wr;

  always_comb begin
    rdata = '0;
    hit   = 1'b1;
    case (csr_idx)
      CSR_MSTATUS:  rdata = XLEN'(mstatus_pack(mstatus_q));
      CSR_MIE:      rdata = XLEN'(mie_pack(mie_q));
      CSR_MTVEC:    rdata = XLEN'(mtvec_q);
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = XLEN'(mepc_q);
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = XLEN'(mtval_q);
      CSR_MCYCLE:   rdata = mcycle[XLEN-1:0];
      CSR_MCYCLEH:  rdata = mcycle[2*XLEN-1:XLEN];
      default:      hit   = 1'b0;
    endcase
  end

  assign csr_rdata       = rdata;
  assign csr_access_ilgl = (csr_rd_en || csr_wr_en) && !hit;
  // Unmapped addresses never reach any register.
  assign sw_wr           = csr_wr_en && hit;

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;

    if (cmt_status_ena) begin
      mstatus_d.mpie = mstatus_q.mie;
      mstatus_d.mie  = 1'b0;
    end else if (cmt_mret_ena) begin
      mstatus_d.mie  = mstatus_q.mpie;
      mstatus_d.mpie = 1'b1;
    end else if (sw_wr && csr_idx == CSR_MSTATUS) begin
      mstatus_d.mie  = csr_wdata[MSTATUS_MIE_BIT];
      mstatus_d.mpie = csr_wdata[MSTATUS_MPIE_BIT];
    end

    if (cmt_epc_ena)                         mepc_d = cmt_epc & EPC_MASK;
    else if (sw_wr && csr_idx == CSR_MEPC)   mepc_d = PC_SIZE'(csr_wdata) & EPC_MASK;

    if (cmt_cause_ena)                       mcause_d = cmt_cause;
    else if (sw_wr && csr_idx == CSR_MCAUSE) mcause_d = csr_wdata;

    if (cmt_badaddr_ena)                     mtval_d = cmt_badaddr;
    else if (sw_wr && csr_idx == CSR_MTVAL)  mtval_d = ADDR_SIZE'(csr_wdata);

    if (sw_wr && csr_idx == CSR_MIE) begin
      mie_d.meie = csr_wdata[MIE_MEIE_BIT];
      mie_d.mtie = csr_wdata[MIE_MTIE_BIT];
      mie_d.msie = csr_wdata[MIE_MSIE_BIT];
    end
    if (sw_wr && csr_idx == CSR_MTVEC)    mtvec_d    = PC_SIZE'(csr_wdata) & TVEC_MASK;
    if (sw_wr && csr_idx == CSR_MSCRATCH) mscratch_d = csr_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_q  <= '0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET & TVEC_MASK;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  csr_cycle_cnt #(.W(XLEN)) u_cycle_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .stop_i  (cycle_stop),
    .wr_lo_i (sw_wr && csr_idx == CSR_MCYCLE),
    .wr_hi_i (sw_wr && csr_idx == CSR_MCYCLEH),
    .wdata_i (csr_wdata),
    .cnt_o   (mcycle)
  );

  assign csr_mepc_r   = mepc_q;
  assign csr_mtvec_r  = mtvec_q;
  assign status_mie_r = mstatus_q.mie;
  assign mie_r        = mie_q;

endmodule
